// File: rtl/bg_scale_mapper.sv
// ---------------------------------------------------------------------------
// bg_scale_mapper
//
// Maps the VGA raster position (DrawX, DrawY) onto a smaller source image
// held in an external ROM, scaling it up to fill the visible screen, and
// registers the palette colour of the selected texel.
//
// Source coordinates are src_x = floor(DrawX*SRC_W/SCR_W) and
// src_y = floor(DrawY*SRC_H/SCR_H). They are tracked with remainder
// accumulators that use only add, subtract and compare. The image is assumed
// to be no larger than the screen (SRC_W <= SCR_W, SRC_H <= SCR_H), so a
// source coordinate steps by at most one per pixel or per line.
//
// Pipeline (latency 3 from DrawX/DrawY to colour):
//   stage 1: rom_addr = row_base + src_x, registered
//   stage 2: external ROM read (rom_q), passed straight to pal_index
//   stage 3: pal_red/green/blue registered into red/green/blue
// Blank, in-range and sync-valid travel alongside the address. The colour is
// forced to black unless all three are set.
//
// Optional feature: define BG_SCROLL_EN to add input scroll_x. It is a
// horizontal scroll with wrap. scroll_x is sampled only at frame start, and
// values >= SRC_W are ignored.
//
// Ports:
//   vga_clk            pixel clock, all state on its rising edge
//   reset_n            asynchronous active-low reset
//   DrawX, DrawY       current pixel column / row
//   blank              display enable, 1 = visible
//   scroll_x           (BG_SCROLL_EN only) horizontal scroll in source pixels
//   rom_addr           registered image ROM address
//   rom_q              ROM data, valid one cycle after rom_addr
//   pal_index          palette index (rom_q passed through)
//   pal_red/green/blue combinational palette result for pal_index
//   red/green/blue     registered pixel colour
// ---------------------------------------------------------------------------
module bg_scale_mapper #(
    parameter int SRC_W  = 105,
    parameter int SRC_H  = 117,
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int ADDR_W = 15,
    parameter int IDX_W  = 4,
    parameter int COL_W  = 4
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
`ifdef BG_SCROLL_EN
    input  logic [ADDR_W-1:0] scroll_x,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [COL_W-1:0]  pal_red,
    input  logic [COL_W-1:0]  pal_green,
    input  logic [COL_W-1:0]  pal_blue,
    output logic [COL_W-1:0]  red,
    output logic [COL_W-1:0]  green,
    output logic [COL_W-1:0]  blue
);

    // The remainders stay below SCR_* but briefly reach SCR_* + SRC_* before
    // the compare.
    localparam int RXW = $clog2(SCR_W + SRC_W + 1);
    localparam int RYW = $clog2(SCR_H + SRC_H + 1);

    localparam logic [RXW-1:0]    C_SRC_W_RX = RXW'(SRC_W);
    localparam logic [RXW-1:0]    C_SCR_W_RX = RXW'(SCR_W);
    localparam logic [RYW-1:0]    C_SRC_H_RY = RYW'(SRC_H);
    localparam logic [RYW-1:0]    C_SCR_H_RY = RYW'(SCR_H);
    localparam logic [ADDR_W-1:0] C_SRC_W_A  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] C_X_MAX    = ADDR_W'(SRC_W - 1);
    localparam logic [ADDR_W-1:0] C_Y_MAX    = ADDR_W'(SRC_H - 1);
    localparam logic [10:0]       C_SCR_W_D  = 11'(SCR_W);
    localparam logic [10:0]       C_SCR_H_D  = 11'(SCR_H);

    // Accumulator state. It holds the values that belong to the previous
    // pixel or line.
    logic [9:0]        r_prev_x;
    logic              r_x_ok;        // line started at DrawX==0 and has stayed sequential
    logic [ADDR_W-1:0] r_sx;
    logic [RXW-1:0]    r_rx;
    logic [ADDR_W-1:0] r_sy;
    logic [RYW-1:0]    r_ry;
    logic [ADDR_W-1:0] r_base;        // r_sy * SRC_W, kept as a running sum
    logic              r_sync_valid;
    logic [2:0]        r_flags_s1;    // {sync, in_range, blank}
    logic [2:0]        r_flags_s2;

    logic              w_frame_start;
    logic              w_line_start;
    logic              w_seq;
    logic [RXW-1:0]    w_rx_sum;
    logic [RXW-1:0]    w_rx;
    logic [ADDR_W-1:0] w_sx;
    logic              w_x_ok;
    logic [RYW-1:0]    w_ry_sum;
    logic [RYW-1:0]    w_ry;
    logic [ADDR_W-1:0] w_sy;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_sx_eff;
    logic              w_in_range;
    logic [2:0]        w_flags_s1;

`ifdef BG_SCROLL_EN
    logic [ADDR_W-1:0] r_scroll;
    logic [ADDR_W-1:0] w_scroll;
    logic [ADDR_W:0]   w_sx_sum;
`endif

    assign pal_index = rom_q;

    always_comb begin
        w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        w_line_start  = (DrawX == 10'd0);
        w_seq         = (DrawX == r_prev_x + 10'd1);

        // Column: the remainder grows by SRC_W per pixel. Each wrap past
        // SCR_W is one source-column step. src_x saturates at the last column.
        w_rx_sum = r_rx + C_SRC_W_RX;
        w_rx     = r_rx;
        w_sx     = r_sx;
        w_x_ok   = 1'b0;
        if (w_line_start) begin
            w_rx   = '0;
            w_sx   = '0;
            w_x_ok = 1'b1;
        end else if (r_x_ok && w_seq) begin
            w_x_ok = 1'b1;
            if (w_rx_sum >= C_SCR_W_RX) begin
                w_rx = w_rx_sum - C_SCR_W_RX;
                if (r_sx != C_X_MAX) begin
                    w_sx = r_sx + 1'b1;
                end
            end else begin
                w_rx = w_rx_sum;
            end
        end

        // Row: same scheme, stepped once per line on DrawX==0. The row base
        // moves with src_y, so no multiply is needed for the address.
        w_ry_sum = r_ry + C_SRC_H_RY;
        w_ry     = r_ry;
        w_sy     = r_sy;
        w_base   = r_base;
        if (w_frame_start) begin
            w_ry   = '0;
            w_sy   = '0;
            w_base = '0;
        end else if (w_line_start) begin
            if (w_ry_sum >= C_SCR_H_RY) begin
                w_ry = w_ry_sum - C_SCR_H_RY;
                if (r_sy != C_Y_MAX) begin
                    w_sy   = r_sy + 1'b1;
                    w_base = r_base + C_SRC_W_A;
                end
            end else begin
                w_ry = w_ry_sum;
            end
        end

`ifdef BG_SCROLL_EN
        // The new scroll value applies from the frame-start pixel itself.
        w_scroll = r_scroll;
        if (w_frame_start && (scroll_x < C_SRC_W_A)) begin
            w_scroll = scroll_x;
        end
        w_sx_sum = {1'b0, w_sx} + {1'b0, w_scroll};
        if (w_sx_sum >= {1'b0, C_SRC_W_A}) begin
            w_sx_sum = w_sx_sum - {1'b0, C_SRC_W_A};
        end
        w_sx_eff = w_sx_sum[ADDR_W-1:0];
`else
        w_sx_eff = w_sx;
`endif

        // A broken column sequence counts as out of range, so the rest of the
        // line is black.
        w_in_range = ({1'b0, DrawX} < C_SCR_W_D) && ({1'b0, DrawY} < C_SCR_H_D) && w_x_ok;
        w_flags_s1 = {r_sync_valid | w_frame_start, w_in_range, blank};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_x     <= '0;
            r_x_ok       <= 1'b0;
            r_sx         <= '0;
            r_rx         <= '0;
            r_sy         <= '0;
            r_ry         <= '0;
            r_base       <= '0;
            r_sync_valid <= 1'b0;
            r_flags_s1   <= '0;
            r_flags_s2   <= '0;
            rom_addr     <= '0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
`ifdef BG_SCROLL_EN
            r_scroll     <= '0;
`endif
        end else begin
            r_prev_x     <= DrawX;
            r_x_ok       <= w_x_ok;
            r_sx         <= w_sx;
            r_rx         <= w_rx;
            r_sy         <= w_sy;
            r_ry         <= w_ry;
            r_base       <= w_base;
            r_sync_valid <= r_sync_valid | w_frame_start;
            rom_addr     <= w_base + w_sx_eff;                  // stage 1
            r_flags_s1   <= w_flags_s1;
            r_flags_s2   <= r_flags_s1;                         // stage 2 (ROM read)
            if (&r_flags_s2) begin                              // stage 3
                red   <= pal_red;
                green <= pal_green;
                blue  <= pal_blue;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
`ifdef BG_SCROLL_EN
            r_scroll     <= w_scroll;
`endif
        end
    end

endmodule

// File: tb/tb_bg_scale_mapper.sv
// ---------------------------------------------------------------------------
// tb_bg_scale_mapper
//
// Scoreboard bench for bg_scale_mapper. Each driven pixel pushes an expected
// address, due one cycle later, and an expected colour, due three cycles
// later. Both are computed from the floor formulas with a multiplier and a
// divider, plus a behavioural ROM and palette.
// ---------------------------------------------------------------------------
module tb_bg_scale_mapper;

    localparam int SRC_W  = 105;
    localparam int SRC_H  = 117;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int ADDR_W = 15;
    localparam int IDX_W  = 4;
    localparam int COL_W  = 4;

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        DrawX   = '0;
    logic [9:0]        DrawY   = '0;
    logic              blank   = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q   = '0;
    logic [IDX_W-1:0]  pal_index;
    logic [COL_W-1:0]  pal_red, pal_green, pal_blue;
    logic [COL_W-1:0]  red, green, blue;
`ifdef BG_SCROLL_EN
    logic [ADDR_W-1:0] scroll_x = '0;
`endif

    always #5 vga_clk = ~vga_clk;

    bg_scale_mapper dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
`ifdef BG_SCROLL_EN
        .scroll_x  (scroll_x),
`endif
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pal_index (pal_index),
        .pal_red   (pal_red),
        .pal_green (pal_green),
        .pal_blue  (pal_blue),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // Behavioural image ROM (one-cycle read) and combinational palette.
    function automatic logic [3:0] rom_val(input logic [14:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
    endfunction

    always @(posedge vga_clk) rom_q <= rom_val(rom_addr);

    assign pal_red   = pal_index ^ 4'hA;
    assign pal_green = pal_index + 4'd3;
    assign pal_blue  = ~pal_index;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit chk;
        int val;
        int x;
        int y;
        int sc;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_col[$];

    // Bench-side model state.
    int m_prev_x  = 0;
    bit m_xok     = 0;
    bit m_sync    = 0;
    bit m_addr_ok = 0;
    int m_scroll  = 0;

    function automatic int exp_addr(input int x, input int y, input int sc);
        int sx;
        int sy;
        sx = (x * SRC_W) / SCR_W;
        sy = (y * SRC_H) / SCR_H;
        if (sx > SRC_W - 1) sx = SRC_W - 1;
        if (sy > SRC_H - 1) sy = SRC_H - 1;
        sx = sx + sc;
        if (sx >= SRC_W) sx = sx - SRC_W;
        return sy * SRC_W + sx;
    endfunction

    function automatic int exp_rgb(input int a);
        logic [3:0] idx;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        idx = rom_val(a[14:0]);
        r = idx ^ 4'hA;
        g = idx + 4'd3;
        b = ~idx;
        return int'({r, g, b});
    endfunction

    // One pixel: compare what is due now, then drive the next pixel and
    // queue its expectations.
    task automatic cyc(input int x, input int y, input bit b);
        exp_t e;
        int   a;
        bit   inr;
        @(negedge vga_clk);
        if (q_addr.size() >= 1) begin
            e = q_addr.pop_front();
            if (e.chk) begin
                check("addr", rom_addr, e.val);
                if (e.sc == 0 && e.x == 320 && e.y == 240) check("addr_320_240", rom_addr, 6142);
                if (e.sc == 0 && e.x == 639 && e.y == 479) check("addr_639_479", rom_addr, 12284);
                if (e.sc == 0 && e.x == 0   && e.y == 0)   check("addr_0_0", rom_addr, 0);
                if (e.sc == 10 && e.x == 639 && e.y == 0)  check("addr_scroll_wrap", rom_addr, 9);
            end
        end
        check("addr_max", rom_addr <= 15'd12284, 1);
        if (q_col.size() >= 3) begin
            e = q_col.pop_front();
            if (e.chk) check("rgb", {red, green, blue}, e.val);
        end

        DrawX = x[9:0];
        DrawY = y[9:0];
        blank = b;
        if (x == 0 && y == 0) begin
            m_sync    = 1;
            m_addr_ok = 1;
`ifdef BG_SCROLL_EN
            if (int'(scroll_x) < SRC_W) m_scroll = int'(scroll_x);
`endif
        end
        if (x == 0) m_xok = 1;
        else if (x != ((m_prev_x + 1) % 1024)) m_xok = 0;
        m_prev_x = x;
        a   = exp_addr(x, y, m_scroll);
        inr = (x < SCR_W) && (y < SCR_H) && m_xok;
        q_addr.push_back('{m_addr_ok && m_xok, a, x, y, m_scroll});
        q_col.push_back('{1'b1, (b && inr && m_sync) ? exp_rgb(a) : 0, x, y, m_scroll});
    endtask

    // One raster line of len pixels with the standard blanking. Row 40 has a
    // blank hole inside the visible area. Row 80 keeps blank high past the
    // right edge. Row 160 jumps from column 99 to 300.
    task automatic line(input int y, input int len);
        int xs;
        bit b;
        for (int x = 0; x < len; x++) begin
            xs = (y == 160 && x >= 100) ? x + 200 : x;
            b  = (xs < SCR_W) && (y < SCR_H);
            if (y == 40 && xs >= 200 && xs < 220) b = 0;
            if (y == 80) b = 1;
            cyc(xs, y, b);
        end
    endtask

    task automatic pulse_reset();
        @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        check("rst_addr_now", rom_addr, 0);
        check("rst_rgb_now", {red, green, blue}, 0);
        q_addr.delete();
        q_col.delete();
        m_sync = 0; m_addr_ok = 0; m_xok = 0; m_prev_x = 0; m_scroll = 0;
        @(negedge vga_clk);
        check("rst_rgb_hold", {red, green, blue}, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge vga_clk);
        check("reset_addr", rom_addr, 0);
        check("reset_rgb", {red, green, blue}, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Frame 1: full lines every 40 rows and on the last row, short lines
        // elsewhere, then a few rows below the screen.
        for (int y = 0; y < 485; y++) begin
            if (y % 40 == 0 || y == 479) line(y, 800);
            else line(y, 4);
        end

        // Frame 2: reset in the middle of row 100, then black until frame start.
        for (int y = 0; y < 100; y++) line(y, 4);
        for (int x = 0; x < 50; x++) cyc(x, 100, 1);
        pulse_reset();
        for (int x = 50; x < 120; x++) cyc(x, 100, 1);
        for (int y = 101; y < 110; y++) line(y, 300);

        // Frame 3: colours return after frame start.
`ifdef BG_SCROLL_EN
        scroll_x = 15'd10;
`endif
        line(0, 800);
        line(1, 4);

        // Frame 4: an out-of-range scroll value must be ignored.
`ifdef BG_SCROLL_EN
        scroll_x = 15'd200;
`endif
        line(0, 800);
        line(1, 4);
        for (int x = 0; x < 4; x++) cyc(x + 700, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_scale_mapper.md
BG_SCALE_MAPPER -- requirements
Module: bg_scale_mapper

Interface
REQ-001 SHALL have parameter SRC_W, default 105, meaning source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 117, meaning source image height in pixels.
REQ-003 SHALL have parameter SCR_W, default 640, meaning visible screen width.
REQ-004 SHALL have parameter SCR_H, default 480, meaning visible screen height.
REQ-005 SHALL have parameter ADDR_W, default 15, meaning ROM address width.
REQ-006 SHALL have parameter IDX_W, default 4, meaning palette index width.
REQ-007 SHALL have parameter COL_W, default 4, meaning colour channel width.
REQ-008 SHALL have port vga_clk, input, 1, pixel clock: one clock, all state on its rising edge.
REQ-009 SHALL have port reset_n, input, 1, reset: asynchronous, active-low.
REQ-010 SHALL have port DrawX, input, 10, current pixel column.
REQ-011 SHALL have port DrawY, input, 10, current pixel row.
REQ-012 SHALL have port blank, input, 1, display enable: 1 means visible.
REQ-013 SHALL have port rom_addr, output, ADDR_W, registered image ROM address.
REQ-014 SHALL have port rom_q, input, IDX_W, ROM data, valid one cycle after rom_addr.
REQ-015 SHALL have port pal_index, output, IDX_W, palette index driven from rom_q.
REQ-016 SHALL have ports pal_red, pal_green, pal_blue, input, COL_W each, combinational palette result.
REQ-017 SHALL have ports red, green, blue, output, COL_W each, registered pixel colour.

Function
REQ-018 SHALL compute src_x = floor(DrawX*SRC_W/SCR_W) and src_y = floor(DrawY*SRC_H/SCR_H) with incremental accumulators (add/subtract/compare only, no multiplier or divider).
REQ-019 SHALL restart the column accumulator when DrawX==0; the column accumulator advances once per cycle, and DrawX is required to increment by 1 per cycle within a line.
REQ-020 SHALL advance the row accumulator once per line at DrawX==0 and restart it when DrawX==0 and DrawY==0 (frame start).
REQ-021 SHALL form rom_addr = src_y*SRC_W + src_x using a running row base (base += SRC_W per source-row step), registered: stage 1.
REQ-022 SHALL pipeline blank and an in-range flag (DrawX<SCR_W and DrawY<SCR_H) alongside the address through stages 1-3.
REQ-023 SHALL stage 2 be the ROM read, and stage 3 register pal_red/green/blue into red/green/blue; total latency from DrawX/DrawY to colour is exactly 3 cycles.
REQ-024 SHALL drive red/green/blue = 0 in stage 3 when delayed blank==0, in-range==0, or sync-valid==0.
REQ-025 SHALL hold src_x at SRC_W-1 and src_y at SRC_H-1 and never exceed them, even if DrawX/DrawY run past SCR_W/SCR_H.
REQ-026 SHALL when DrawX jumps non-sequentially mid-line, produce black until the next DrawX==0, with no out-of-image address.

Reset
REQ-027 SHALL on reset_n low clear red/green/blue, rom_addr, all accumulators, pipeline flags and the scroll register to 0 immediately.
REQ-028 SHALL clear sync-valid on reset and set it only at the next frame start; outputs are black until then, including after a mid-frame reset.

Configuration
REQ-029 SHALL with macro BG_SCROLL_EN defined, add input scroll_x (ADDR_W bits), sampled only at frame start, using src_x' = src_x+scroll_x minus SRC_W when >= SRC_W (horizontal wrap); a sampled value >= SRC_W is ignored (previous kept).
REQ-030 SHALL without BG_SCROLL_EN, have no scroll_x port and use src_x' = src_x.

Verification
REQ-031 SHALL cover: default parameters, DrawX=320, DrawY=240, blank=1 -> rom_addr=6142 one cycle later; colour = pal_* for rom_q three cycles after input.
REQ-032 SHALL cover: DrawX=639, DrawY=479 -> rom_addr=12284; DrawX=0, DrawY=0 -> rom_addr=0.
REQ-033 SHALL cover: full-frame sweep -> each rom_addr equals floor formula for all 307200 pixels; no address > 12284.
REQ-034 SHALL cover: blank=0 or DrawX=700 -> red=green=blue=0 at latency 3.
REQ-035 SHALL cover: reset_n pulsed low at DrawY=100 -> outputs 0 immediately and until next frame start, then correct colours.
REQ-036 SHALL cover: BG_SCROLL_EN with scroll_x=10, DrawX=639 -> src_x'=(104+10)-105=9; scroll_x=200 ignored.
